// File: rtl/step_pulse_scheduler.sv
// step_pulse_scheduler: ramps a step/dir stream toward a requested period with pulse-width and dir-setup guarantees.
module step_pulse_scheduler #(
  parameter int WIDTH_WORK = 16,
  parameter int PULSE_W    = 50,
  parameter int DIR_SETUP  = 250,
  parameter int N_MIN      = 100,
  parameter int N_START    = 2000,
  parameter int RAMP_STEP  = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  dir_req,
  input  logic [WIDTH_WORK-1:0] period_in,
  input  logic                  period_valid,
  output logic                  drv_step,
  output logic                  drv_dir,
  output logic                  busy,
  output logic [31:0]           position
);
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;
  localparam int W1 = WIDTH_WORK + 1;
  state_t state;
  logic [WIDTH_WORK-1:0] target, cur_per, nxt_per, ramped;
  logic [W1-1:0] timer, low_end;
  logic low_done, rise;
  // cur_per times the interval that started at the latest rise; nxt_per is the one after it
  always_comb begin
    ramped   = ({1'b0, nxt_per} > {1'b0, target} + W1'(RAMP_STEP)) ? nxt_per - WIDTH_WORK'(RAMP_STEP) : target;
    low_end  = {1'b0, cur_per} - W1'(PULSE_W + 1);
    low_done = (state == LOW) && (timer == low_end);
    rise     = (state == SETUP && enable && timer == W1'(DIR_SETUP)) ||
               (low_done && enable && target != '0 && dir_req == drv_dir);
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      drv_step <= 1'b0;
      drv_dir  <= 1'b0;
      position <= '0;
      target   <= '0;
      cur_per  <= WIDTH_WORK'(N_START);
      nxt_per  <= WIDTH_WORK'(N_START);
      timer    <= '0;
    end else begin
      timer <= timer + 1'b1;
      if (period_valid)
        target <= (period_in == '0) ? '0 : (period_in < WIDTH_WORK'(N_MIN)) ? WIDTH_WORK'(N_MIN) : period_in;
      if (rise) begin
        state    <= HIGH;
        drv_step <= 1'b1;
        timer    <= '0;
        position <= drv_dir ? position + 32'd1 : position - 32'd1;
        cur_per  <= nxt_per;
        nxt_per  <= ramped;
      end else begin
        case (state)
          IDLE: if (enable && target != '0) begin
            state   <= SETUP;
            drv_dir <= dir_req;
            nxt_per <= WIDTH_WORK'(N_START);
            timer   <= '0;
          end
          SETUP: if (!enable) state <= IDLE;
          HIGH: if (timer == W1'(PULSE_W - 1)) begin
            drv_step <= 1'b0;
            timer    <= '0;
            state    <= enable ? LOW : IDLE;
          end
          LOW: if (low_done) begin
            timer <= '0;
            if (!enable || target == '0) state <= IDLE;
            else begin
              state   <= SETUP;
              drv_dir <= dir_req;
              nxt_per <= WIDTH_WORK'(N_START);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_step_pulse_scheduler.sv
// tb_step_pulse_scheduler: scoreboard bench; expected rise times/dir/position come from a ramp model of the scheduler rules.
module tb_step_pulse_scheduler;
  logic clk = 0, rst = 1, enable = 0, dir_req = 0, period_valid = 0;
  logic [15:0] period_in = '0;
  logic drv_step, drv_dir, busy;
  logic [31:0] position;

  step_pulse_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .dir_req(dir_req),
    .period_in(period_in), .period_valid(period_valid),
    .drv_step(drv_step), .drv_dir(drv_dir), .busy(busy), .position(position)
  );

  always #5 clk = ~clk;

  typedef struct {int t; bit d; int pos;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int total = 0, bad = 0, cyc = 0, rises_seen = 0, rise_cyc = 0, mpos = 0;
  bit prev = 0;

  always @(posedge clk) cyc++;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every rising edge of drv_step must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst) prev = 0;
    else begin
      if (drv_step && !prev) begin
        rises_seen++;
        rise_cyc = cyc;
        check(exp_q.size() > 0, "rise_expected", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check(cyc == mon_e.t, "rise_time", cyc, mon_e.t);
          check(drv_dir == mon_e.d, "rise_dir", drv_dir, mon_e.d);
          check($signed(position) == mon_e.pos, "position", $signed(position), mon_e.pos);
        end
      end
      if (!drv_step && prev) check(cyc - rise_cyc == 50, "high_width", cyc - rise_cyc, 50);
      prev = drv_step;
    end
  end

  function automatic int clampf(input int p);
    return (p == 0) ? 0 : (p < 100) ? 100 : p;
  endfunction

  task automatic strobe(input int p);
    period_in = 16'(p);
    period_valid = 1;
    @(negedge clk);
    period_valid = 0;
  endtask

  task automatic wait_rise(input int n);
    for (int i = 0; i < 5000 && rises_seen < n; i++) @(negedge clk);
    check(rises_seen >= n, "rise_timeout", rises_seen, n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
    check(!busy, "idle_timeout", busy, 0);
    check(!drv_step, "step_low_idle", drv_step, 0);
  endtask

  // One run: ramp in direction d, optional retarget after first rise, optional reversal, then stop
  task automatic run(input int p1, input int p2, input bit chg, input bit d,
                     input int k1, input bit rev, input int k2, input bit stop_en);
    int t, nxt, cur, tg, n, g, base, tot;
    bit dd;
    @(negedge clk);
    strobe(p1);
    enable = 1;
    dir_req = d;
    base = rises_seen;
    t = cyc + 252;
    g = 0;
    for (int s = 0; s < (rev ? 2 : 1); s++) begin
      dd = (s != 0) ? !d : d;
      nxt = 2000;
      n = (s != 0) ? k2 : k1;
      for (int j = 0; j < n; j++) begin
        mpos += dd ? 1 : -1;
        exp_q.push_back('{t, dd, mpos});
        tg = clampf((chg && g > 0) ? p2 : p1);
        cur = nxt;
        nxt = (nxt > tg + 100) ? nxt - 100 : tg;
        t += cur + ((j == n - 1) ? 251 : 0);
        g++;
      end
    end
    tot = g;
    for (int i = 0; i < tot; i++) begin
      wait_rise(base + i + 1);
      if (i == 0 && chg) strobe(p2);
      if (rev && i == k1 - 1) dir_req = !d;
    end
    if (stop_en) begin
      repeat (9) @(negedge clk);
      enable = 0;
      repeat (50) @(negedge clk);
      check(!busy, "busy_after_enable_drop", busy, 0);
      check(!drv_step, "step_after_enable_drop", drv_step, 0);
    end else begin
      strobe(0);
      wait_idle();
      enable = 0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check(drv_step == 0, "rst_step", drv_step, 0);
    check(drv_dir == 0, "rst_dir", drv_dir, 0);
    check(busy == 0, "rst_busy", busy, 0);
    check(position == 0, "rst_position", position, 0);
    rst = 0;
    @(negedge clk);
    check(busy == 0, "post_rst_busy", busy, 0);
    // enable withdrawn during dir setup: no pulse
    strobe(500);
    enable = 1;
    dir_req = 1;
    repeat (100) @(negedge clk);
    check(busy == 1, "setup_busy", busy, 1);
    enable = 0;
    repeat (3) @(negedge clk);
    check(busy == 0, "setup_abort_idle", busy, 0);
    repeat (300) @(negedge clk);
    check(rises_seen == 0, "setup_abort_no_pulse", rises_seen, 0);
    // clamp to N_MIN: full ramp 2000 -> 100 with two steady 100-cycle periods
    run(20, 0, 0, 1, 22, 0, 0, 0);
    // reversal mid-run
    run(600, 0, 0, 1, 2, 1, 2, 0);
    // enable dropped early in a pulse
    run(700, 0, 0, 0, 2, 0, 0, 1);
    for (int k = 0; k < 3; k++)
      run($urandom_range(20, 1500), $urandom_range(20, 3000), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom_range(1, 2), 1'($urandom_range(0, 1)),
          $urandom_range(1, 2), 1'($urandom_range(0, 1)));
    // async reset in the middle of a pulse
    @(negedge clk);
    strobe(800);
    enable = 1;
    dir_req = 1;
    mpos += 1;
    exp_q.push_back('{cyc + 252, 1'b1, mpos});
    wait_rise(rises_seen + 1);
    repeat (10) @(negedge clk);
    #2 rst = 1;
    #1;
    check(drv_step == 0, "async_rst_step", drv_step, 0);
    check(position == 0, "async_rst_position", position, 0);
    check(busy == 0, "async_rst_busy", busy, 0);
    mpos = 0;
    enable = 0;
    @(negedge clk);
    #2 rst = 0;
    repeat (400) @(negedge clk);
    check(!busy, "no_restart_after_rst", busy, 0);
    run(300, 0, 0, 0, 2, 0, 0, 0);
    repeat (5) @(negedge clk);
    check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
